// File: rtl/ic74ls161_pkg.sv
// ---------------------------------------------------------------------------
// ic74ls161_pkg
// Shared constants and helpers for the 74LS161 4-bit synchronous binary
// counter model.
//   TPD_Q    : nominal CLK/clear to QA..QD delay in sim time units. The model
//              is zero-delay, so this value is 0.
//   TPD_RCO  : nominal Q/ENT to RCO delay in sim time units. The model is
//              zero-delay, so this value is 0.
//   CNT_W    : counter width.
//   CNT_MAX  : terminal count, the value at which RCO can assert.
//   rco_of() : ripple-carry output as a function of count and ENT.
// ---------------------------------------------------------------------------
package ic74ls161_pkg;

   localparam int unsigned TPD_Q   = 0;
   localparam int unsigned TPD_RCO = 0;
   localparam int unsigned CNT_W   = 4;
   localparam logic [3:0]  CNT_MAX = 4'hF;

   // Carry is gated by ENT so a cascade stalls as soon as any lower stage stops.
   function automatic logic rco_of(input logic [3:0] q, input logic ent);
      return ent & (q == CNT_MAX);
   endfunction

endpackage

// File: rtl/ic74ls161_if.sv
// ---------------------------------------------------------------------------
// ic74ls161_if
// Pin bundle of the 74LS161 apart from CLK (port2) and CLR_n (port1), which
// stay scalar ports on the counter. Signals keep their package pin numbers.
//   port3..port6 : A..D parallel load data (A = LSB)
//   port7        : ENP count enable P
//   port8        : GND (not used by the model)
//   port9        : LOAD_n synchronous active-low load
//   port10       : ENT count enable T, also gates RCO
//   port11..14   : QD..QA count outputs (QA = LSB)
//   port15       : RCO ripple carry out
//   port16       : VCC (not used by the model)
// Modports: master drives the inputs and observes outputs (board side);
//           slave is the counter itself.
// ---------------------------------------------------------------------------
interface ic74ls161_if;
   import ic74ls161_pkg::*;

   logic port3;
   logic port4;
   logic port5;
   logic port6;
   logic port7;
   logic port8;
   logic port9;
   logic port10;
   logic port11;
   logic port12;
   logic port13;
   logic port14;
   logic port15;
   logic port16;

   modport master (
      output port3, port4, port5, port6, port7, port8, port9, port10, port16,
      input  port11, port12, port13, port14, port15
   );

   modport slave (
      input  port3, port4, port5, port6, port7, port8, port9, port10, port16,
      output port11, port12, port13, port14, port15
   );

endinterface

// File: rtl/ic74ls161.sv
// ---------------------------------------------------------------------------
// ic74ls161
// 74LS161 4-bit synchronous binary counter: asynchronous clear, synchronous
// parallel load, count enables ENP/ENT and combinational ripple carry.
// Ports:
//   port2 : CLK, rising-edge active
//   port1 : CLR_n, asynchronous active-low clear (q = 0 while low)
//   bus   : ic74ls161_if.slave carrying A..D, ENP, ENT, LOAD_n, QA..QD, RCO,
//           GND and VCC
// Edge priority with CLR_n high: LOAD_n=0 loads {D,C,B,A}; else ENP&ENT
// increments modulo 16; else hold. RCO = ENT & (q == 4'hF), not registered.
// Optional build macro IC74LS161_CHECK_EN: at each rising CLK with CLR_n high,
// report X/Z on LOAD_n, ENP, ENT (and A..D while loading) with $error and
// drive the count to all-X. Without the macro no checks are made.
// ---------------------------------------------------------------------------
module ic74ls161
   import ic74ls161_pkg::*;
(
   input  logic         port2,
   input  logic         port1,
   ic74ls161_if.slave   bus
);

   logic [3:0] q_r;
   logic [3:0] next_q_s;
   logic [3:0] load_s;
   logic       unused_pins_s;

   assign load_s        = {bus.port6, bus.port5, bus.port4, bus.port3};
   // Supply pins exist only for pin accuracy.
   assign unused_pins_s = bus.port8 ^ bus.port16;

   // Next count: load beats counting, counting needs both enables.
   always_comb begin
      next_q_s = q_r;
      if (bus.port9 == 1'b0) begin
         next_q_s = load_s;
      end else if ((bus.port7 == 1'b1) && (bus.port10 == 1'b1)) begin
         next_q_s = q_r + 4'd1;
      end else begin
         next_q_s = q_r;
      end
   end

   // Count register; clear is asynchronous and blocks clock edges while low.
   always_ff @(posedge port2 or negedge port1) begin
      if (!port1) begin
         q_r <= 4'h0;
      end
`ifdef IC74LS161_CHECK_EN
      else if ($isunknown({bus.port9, bus.port7, bus.port10}) ||
               ((bus.port9 == 1'b0) && $isunknown(load_s))) begin
         $error("ic74ls161: unknown control or load data at CLK edge");
         q_r <= 4'hx;
      end
`endif
      else begin
         q_r <= next_q_s;
      end
   end

   assign bus.port14 = q_r[0];
   assign bus.port13 = q_r[1];
   assign bus.port12 = q_r[2];
   assign bus.port11 = q_r[3];
   assign bus.port15 = rco_of(q_r, bus.port10);

endmodule

// File: tb/tb_ic74ls161.sv
// ---------------------------------------------------------------------------
// tb_ic74ls161
// Directed bench for ic74ls161: clear behaviour, free counting with wrap,
// load priority, enable gating, RCO following ENT, clear racing a clock edge
// and a two-stage cascade through RCO -> ENT. Expected values are written out
// by hand in each step.
// ---------------------------------------------------------------------------
module tb_ic74ls161;

   logic port1;
   logic port2;

   ic74ls161_if u_if0 ();
   ic74ls161_if u_if1 ();

   ic74ls161 u_dut0 (
      .port2 (port2),
      .port1 (port1),
      .bus   (u_if0.slave)
   );

   ic74ls161 u_dut1 (
      .port2 (port2),
      .port1 (port1),
      .bus   (u_if1.slave)
   );

   // Upper stage counts only when the lower stage carries.
   assign u_if1.port10 = u_if0.port15;

   logic [3:0] q0_s;
   logic [3:0] q1_s;
   assign q0_s = {u_if0.port11, u_if0.port12, u_if0.port13, u_if0.port14};
   assign q1_s = {u_if1.port11, u_if1.port12, u_if1.port13, u_if1.port14};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full clock period; returns on the falling edge, away from the active edge.
   task automatic tick();
      #5 port2 = 1'b1;
      #5 port2 = 1'b0;
   endtask

   task automatic set_data(input logic [3:0] d);
      u_if0.port3 = d[0];
      u_if0.port4 = d[1];
      u_if0.port5 = d[2];
      u_if0.port6 = d[3];
   endtask

   initial begin
      port2 = 1'b0;
      port1 = 1'b0;
      set_data(4'hF);
      u_if0.port7  = 1'b1;
      u_if0.port8  = 1'b0;
      u_if0.port9  = 1'b0;
      u_if0.port10 = 1'b1;
      u_if0.port16 = 1'b1;
      u_if1.port3  = 1'b0;
      u_if1.port4  = 1'b0;
      u_if1.port5  = 1'b0;
      u_if1.port6  = 1'b0;
      u_if1.port7  = 1'b1;
      u_if1.port8  = 1'b0;
      u_if1.port9  = 1'b1;
      u_if1.port16 = 1'b1;
      #3;

      // 1. Clear held low while CLK toggles and a load of F is requested.
      tick(); tick(); tick();
      check("clr_hold_q", {4'h0, q0_s}, 8'h00);
      check("clr_hold_rco", {7'h0, u_if0.port15}, 8'h00);
      #2 port1 = 1'b1;
      u_if0.port9 = 1'b1;
      tick();
      check("post_clr_count", {4'h0, q0_s}, 8'h01);

      // 2. Free count of 20 edges from 0.
      port1 = 1'b0;
      #1;
      check("clr_async_a", {4'h0, q0_s}, 8'h00);
      port1 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         check($sformatf("count_q_%0d", i), {4'h0, q0_s}, 8'(i % 16));
         check($sformatf("count_rco_%0d", i), {7'h0, u_if0.port15},
               ((i % 16) == 15) ? 8'h01 : 8'h00);
      end

      // 3. Load 1010 with ENP low, then count once.
      u_if0.port9 = 1'b0;
      u_if0.port7 = 1'b0;
      set_data(4'b1010);
      tick();
      check("load_a", {4'h0, q0_s}, 8'h0A);
      u_if0.port9 = 1'b1;
      u_if0.port7 = 1'b1;
      tick();
      check("load_then_count", {4'h0, q0_s}, 8'h0B);

      // 4. Hold with one enable low, RCO follows ENT without a clock.
      u_if0.port9 = 1'b0;
      set_data(4'h7);
      tick();
      check("load_7", {4'h0, q0_s}, 8'h07);
      u_if0.port9 = 1'b1;
      u_if0.port7 = 1'b0;
      u_if0.port10 = 1'b1;
      tick(); tick(); tick();
      check("hold_enp0", {4'h0, q0_s}, 8'h07);
      u_if0.port7 = 1'b1;
      u_if0.port10 = 1'b0;
      tick(); tick(); tick();
      check("hold_ent0", {4'h0, q0_s}, 8'h07);
      u_if0.port9 = 1'b0;
      u_if0.port7 = 1'b0;
      set_data(4'hF);
      tick();
      check("load_f_ent0_q", {4'h0, q0_s}, 8'h0F);
      check("load_f_ent0_rco", {7'h0, u_if0.port15}, 8'h00);
      u_if0.port9 = 1'b1;
      #1 u_if0.port10 = 1'b1;
      #1;
      check("rco_ent_rise", {7'h0, u_if0.port15}, 8'h01);
      u_if0.port10 = 1'b0;
      #1;
      check("rco_ent_fall", {7'h0, u_if0.port15}, 8'h00);
      u_if0.port10 = 1'b1;
      #1;
      check("rco_ent_rise2", {7'h0, u_if0.port15}, 8'h01);

      // 5. Clear mid-count, then release clear on a clock edge.
      port1 = 1'b0;
      #1 port1 = 1'b1;
      u_if0.port7 = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      check("count_to_9", {4'h0, q0_s}, 8'h09);
      #2 port1 = 1'b0;
      #1;
      check("clr_async_b", {4'h0, q0_s}, 8'h00);
      // The edge is evaluated before the clear release lands, so it is ignored.
      #5 port2 = 1'b1;
      port1 <= 1'b1;
      #5 port2 = 1'b0;
      check("clr_release_edge", {4'h0, q0_s}, 8'h00);
      tick();
      check("after_release", {4'h0, q0_s}, 8'h01);

      // 6. Two cascaded stages, 256 edges from 0.
      port1 = 1'b0;
      #1;
      check("cascade_clr", {q1_s, q0_s}, 8'h00);
      port1 = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i == 16) begin
            check("cascade_16", {q1_s, q0_s}, 8'h10);
         end
         if (i == 255) begin
            check("cascade_255", {q1_s, q0_s}, 8'hFF);
            check("cascade_rco", {6'h0, u_if1.port15, u_if0.port15}, 8'h03);
         end
      end
      check("cascade_wrap", {q1_s, q0_s}, 8'h00);

`ifdef IC74LS161_CHECK_EN
      u_if0.port9 = 1'bx;
      tick();
      check("x_load_n", {4'h0, q0_s}, {4'h0, 4'hx});
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
